hscale_line_feeder: RTL and testbench

- Upstream feeder for the horizontal linear-interpolation stage of the video output path.
- Captures one active line of one colour component at VDP dot rate into a ping-pong line buffer.
- Replays the previous line at the scaled rate: one sample plus one clock-enable strobe every RATIO clocks, driving the interpolator's IDATA/CLKENA pins directly.
- One instance per colour component.

---
 rtl/hscale_pkg.sv | 17 +
 rtl/hscale_line_feeder_if.sv | 23 ++
 rtl/hscale_line_ram.sv | 23 ++
 rtl/hscale_line_feeder.sv | 181 ++++++++++++++++++
 tb/tb_hscale_line_feeder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/hscale_pkg.sv
// Shared types and defaults for the horizontal-scale line feeder.
package hscale_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_TAIL  = 2'd3
    } hscale_state_t;

    localparam int DEF_RATIO      = 6;
    localparam int DEF_DEPTH_LOG2 = 9;

    // Extra strobes needed to push the last pixel through the interpolator's two-deep delay line.
    localparam int TAIL_STROBES   = 2;

endpackage

// File: rtl/hscale_line_feeder_if.sv
// Pixel-in / sample-out signal bundle between the video path and one line feeder.
interface hscale_line_feeder_if #(
    parameter int MSBI = 5
);
    logic            LINE_START;
    logic            WR_EN;
    logic [MSBI:0]   WR_DATA;
    logic            RD_START;
    logic [MSBI:0]   ODATA;
    logic            OCLKENA;
    logic            OACTIVE;
    logic            WR_OVF;

    modport master (
        output LINE_START, WR_EN, WR_DATA, RD_START,
        input  ODATA, OCLKENA, OACTIVE, WR_OVF
    );

    modport slave (
        input  LINE_START, WR_EN, WR_DATA, RD_START,
        output ODATA, OCLKENA, OACTIVE, WR_OVF
    );
endinterface

// File: rtl/hscale_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module hscale_line_ram #(
    parameter int DW = 6,
    parameter int AW = 10
) (
    input  logic          CLK21M,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK21M) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hscale_line_feeder.sv
// Captures one line per component into a ping-pong buffer and replays the previous line
// at one sample every RATIO clocks. HSCALE_FEEDER_TAIL_FLUSH_EN adds two trailing strobes.
module hscale_line_feeder
    import hscale_pkg::*;
#(
    parameter int MSBI       = 5,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int RATIO      = DEF_RATIO
) (
    input  logic                 CLK21M,
    input  logic                 RESET_N,
    hscale_line_feeder_if.slave  bus
);

    localparam int AW   = DEPTH_LOG2;
    localparam int DW   = MSBI + 1;
    localparam int DIVW = $clog2(RATIO);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RATIO - 1);
    localparam logic [AW:0]     ONE      = (AW+1)'(1);

    // ---------------- write side ----------------
    logic          wr_bank_reg;
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_len_reg;
    logic          rd_bank_next_reg;
    logic          wr_ovf_reg;
    logic          wr_full;

    logic          ram_we;
    logic [AW:0]   ram_waddr;
    logic [AW:0]   ram_raddr;
    logic [DW-1:0] ram_rdata;

    // wr_ptr never exceeds capacity, so its MSB alone marks a full bank.
    assign wr_full   = wr_ptr_reg[AW];
    assign ram_we    = bus.WR_EN & (bus.LINE_START | ~wr_full);
    assign ram_waddr = bus.LINE_START ? {~wr_bank_reg, {AW{1'b0}}}
                                      : {wr_bank_reg, wr_ptr_reg[AW-1:0]};

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_bank_reg      <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_len_reg       <= '0;
            rd_bank_next_reg <= 1'b0;
            wr_ovf_reg       <= 1'b0;
        end else if (bus.LINE_START) begin
            rd_len_reg       <= wr_ptr_reg;
            rd_bank_next_reg <= wr_bank_reg;
            wr_bank_reg      <= ~wr_bank_reg;
            wr_ptr_reg       <= bus.WR_EN ? ONE : '0;
            wr_ovf_reg       <= 1'b0;
        end else if (bus.WR_EN) begin
            if (wr_full) begin
                wr_ovf_reg <= 1'b1;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
            end
        end
    end

    // ---------------- read side ----------------
    hscale_state_t state_reg;
    logic [DIVW-1:0] div_reg;
    logic [AW:0]     cnt_reg;
    logic            rd_bank_reg;
    logic [AW-1:0]   rd_addr_reg;
    logic [DW-1:0]   odata_reg;
    logic            oclkena_reg;
    logic            oactive_reg;
`ifdef HSCALE_FEEDER_TAIL_FLUSH_EN
    localparam int TW = (TAIL_STROBES > 1) ? $clog2(TAIL_STROBES) : 1;
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_STROBES - 1);
    logic [TW-1:0]   tail_cnt_reg;
`endif

    // A same-cycle LINE_START must be visible to RD_START: the replay targets the line just closed.
    logic [AW:0] eff_len;
    logic        eff_bank;
    assign eff_len   = bus.LINE_START ? wr_ptr_reg  : rd_len_reg;
    assign eff_bank  = bus.LINE_START ? wr_bank_reg : rd_bank_next_reg;
    assign ram_raddr = {rd_bank_reg, rd_addr_reg};

    hscale_line_ram #(
        .DW (DW),
        .AW (AW + 1)
    ) u_ram (
        .CLK21M (CLK21M),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (bus.WR_DATA),
        .raddr  (ram_raddr),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge CLK21M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= ST_IDLE;
            div_reg      <= '0;
            cnt_reg      <= '0;
            rd_bank_reg  <= 1'b0;
            rd_addr_reg  <= '0;
            odata_reg    <= '0;
            oclkena_reg  <= 1'b0;
            oactive_reg  <= 1'b0;
`ifdef HSCALE_FEEDER_TAIL_FLUSH_EN
            tail_cnt_reg <= '0;
`endif
        end else begin
            oclkena_reg <= 1'b0;
            if (bus.RD_START) begin
                // Restart from any state; an in-flight strobe for this cycle is dropped.
                div_reg <= '0;
                if (eff_len != '0) begin
                    state_reg   <= ST_PRIME;
                    rd_bank_reg <= eff_bank;
                    cnt_reg     <= eff_len;
                    rd_addr_reg <= '0;
                    oactive_reg <= 1'b1;
                end else begin
                    state_reg   <= ST_IDLE;
                    oactive_reg <= 1'b0;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        oactive_reg <= 1'b0;
                    end
                    ST_PRIME: begin
                        state_reg <= ST_RUN;
                        div_reg   <= '0;
                    end
                    ST_RUN: begin
                        if (div_reg == DIV_LAST) begin
                            div_reg     <= '0;
                            odata_reg   <= ram_rdata;
                            oclkena_reg <= 1'b1;
                            cnt_reg     <= cnt_reg - ONE;
                            if (cnt_reg == ONE) begin
`ifdef HSCALE_FEEDER_TAIL_FLUSH_EN
                                state_reg    <= ST_TAIL;
                                tail_cnt_reg <= '0;
`else
                                state_reg    <= ST_IDLE;
`endif
                            end else begin
                                rd_addr_reg <= rd_addr_reg + 1'b1;
                            end
                        end else begin
                            div_reg <= div_reg + 1'b1;
                        end
                    end
`ifdef HSCALE_FEEDER_TAIL_FLUSH_EN
                    ST_TAIL: begin
                        if (div_reg == DIV_LAST) begin
                            div_reg     <= '0;
                            oclkena_reg <= 1'b1;
                            if (tail_cnt_reg == TAIL_LAST) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                tail_cnt_reg <= tail_cnt_reg + 1'b1;
                            end
                        end else begin
                            div_reg <= div_reg + 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ODATA   = odata_reg;
    assign bus.OCLKENA = oclkena_reg;
    assign bus.OACTIVE = oactive_reg;
    assign bus.WR_OVF  = wr_ovf_reg;

endmodule

// File: tb/tb_hscale_line_feeder.sv
// Bench for hscale_line_feeder: every cycle is compared against a line/strobe-schedule model.
module tb_hscale_line_feeder;

    localparam int MSBI  = 5;
    localparam int DW    = MSBI + 1;
    localparam int DEPTH = 9;
    localparam int CAP   = 1 << DEPTH;
    localparam int RATIO = 6;
`ifdef HSCALE_FEEDER_TAIL_FLUSH_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hscale_line_feeder_if #(.MSBI(MSBI)) bus ();

    hscale_line_feeder #(
        .MSBI       (MSBI),
        .DEPTH_LOG2 (DEPTH),
        .RATIO      (RATIO)
    ) dut (
        .CLK21M  (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int dut_strobes = 0;

    // Reference model: the open line, the last closed line, and a list of timed strobes.
    typedef struct {
        longint        t;
        logic [DW-1:0] v;
    } ev_t;

    logic [DW-1:0] cur_q[$];
    logic [DW-1:0] last_q[$];
    ev_t           sched[$];
    longint        cyc;
    longint        active_end;
    bit            active_m;
    bit            ovf_m;
    bit            exp_clk;
    logic [DW-1:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        cur_q.delete();
        last_q.delete();
        sched.delete();
        active_m = 0;
        active_end = 0;
        ovf_m = 0;
        exp_clk = 0;
        exp_data = '0;
    endtask

    task automatic model_edge(input bit ls, input bit we, input bit rs, input logic [DW-1:0] d);
        ev_t e;
        cyc++;
        if (ls) begin
            last_q = cur_q;
            cur_q.delete();
            ovf_m = 0;
        end
        if (we) begin
            if (cur_q.size() < CAP) cur_q.push_back(d);
            else ovf_m = 1;
        end
        if (rs) begin
            sched.delete();
            active_m = 0;
            if (last_q.size() != 0) begin
                for (int k = 0; k < last_q.size() + EXTRA; k++) begin
                    e.t = cyc + RATIO + 1 + longint'(k) * RATIO;
                    e.v = (k < last_q.size()) ? last_q[k] : last_q[last_q.size() - 1];
                    sched.push_back(e);
                end
                active_m = 1;
                active_end = sched[sched.size() - 1].t;
            end
        end
        exp_clk = 0;
        if (sched.size() != 0 && sched[0].t == cyc) begin
            exp_clk = 1;
            exp_data = sched[0].v;
            void'(sched.pop_front());
        end
    endtask

    function automatic bit model_busy();
        return active_m && (cyc <= active_end + 1);
    endfunction

    task automatic check_outputs();
        chk("oclkena", 32'(bus.OCLKENA), 32'(exp_clk));
        chk("odata",   32'(bus.ODATA),   32'(exp_data));
        chk("oactive", 32'(bus.OACTIVE), 32'(active_m && (cyc <= active_end)));
        chk("wr_ovf",  32'(bus.WR_OVF),  32'(ovf_m));
        if (bus.OCLKENA === 1'b1) dut_strobes++;
    endtask

    task automatic tick(input bit ls, input bit we, input bit rs, input logic [DW-1:0] d);
        bus.LINE_START = ls;
        bus.WR_EN      = we;
        bus.RD_START   = rs;
        bus.WR_DATA    = d;
        @(posedge clk);
        if (rst_n) model_edge(ls, we, rs, d);
        #1;
        bus.LINE_START = 1'b0;
        bus.WR_EN      = 1'b0;
        bus.RD_START   = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, DW'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && model_busy(); i++) idle(1);
    endtask

    initial begin
        int base;
        bus.LINE_START = 1'b0;
        bus.WR_EN      = 1'b0;
        bus.RD_START   = 1'b0;
        bus.WR_DATA    = '0;
        cyc = 0;
        model_reset();

        // Reset and quiet idle, then RD_START on an empty buffer.
        #2 rst_n = 1'b0;
        idle(3);
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        tick(0, 0, 1, '0);
        idle(12);

        // Three-pixel line replayed at RATIO spacing.
        tick(0, 1, 0, 6'h05);
        tick(0, 1, 0, 6'h2A);
        tick(0, 1, 0, 6'h3F);
        tick(1, 0, 0, '0);
        tick(0, 0, 1, '0);
        idle(RATIO * (3 + EXTRA) + 4);

        // Capacity: one write past full, then a full-length replay.
        for (int i = 0; i < CAP + 1; i++) tick(0, 1, 0, DW'($urandom));
        chk("cap_ovf_set", 32'(bus.WR_OVF), 32'd1);
        tick(1, 0, 0, '0);
        chk("cap_ovf_clr", 32'(bus.WR_OVF), 32'd0);
        base = dut_strobes;
        tick(0, 0, 1, '0);
        drain();
        idle(3);
        chk("cap_strobes", 32'(dut_strobes - base), 32'(CAP + EXTRA));

        // Simultaneous LINE_START and RD_START replay the line just closed.
        tick(0, 1, 0, 6'h10);
        tick(0, 1, 0, 6'h11);
        tick(1, 0, 1, '0);
        drain();
        idle(2);

        // Restart at the edge of the second strobe.
        for (int i = 0; i < 4; i++) tick(0, 1, 0, DW'($urandom));
        tick(1, 0, 0, '0);
        tick(0, 0, 1, '0);
        idle(2 * RATIO);
        tick(0, 0, 1, '0);
        drain();
        idle(2);

        // Reset in the middle of a replay.
        for (int i = 0; i < 5; i++) tick(0, 1, 0, DW'($urandom));
        tick(1, 0, 1, '0);
        idle(3 * RATIO);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_odata",   32'(bus.ODATA),   32'd0);
        chk("rst_oclkena", 32'(bus.OCLKENA), 32'd0);
        chk("rst_oactive", 32'(bus.OACTIVE), 32'd0);
        chk("rst_wr_ovf",  32'(bus.WR_OVF),  32'd0);
        model_reset();
        idle(2);
        @(negedge clk) rst_n = 1'b1;
        tick(0, 0, 1, '0);
        idle(3 * RATIO);

        // Randomized lines; a new line closes only after the previous replay has drained.
        for (int ln = 0; ln < 14; ln++) begin
            int n;
            int written;
            int mode;
            n = $urandom_range(0, 24);
            written = 0;
            while (written < n) begin
                bit we;
                we = ($urandom_range(0, 2) != 0);
                tick(0, we, 0, DW'($urandom));
                if (we) written++;
            end
            drain();
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                tick(1, 1'($urandom), 1, DW'($urandom));
            end else begin
                tick(1, 1'($urandom), 0, DW'($urandom));
                idle($urandom_range(0, 5));
                if (mode == 1) tick(0, 0, 1, '0);
            end
        end
        drain();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
